// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the systolic array memory side.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ACCUM_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH  = 10;

  typedef enum logic [1:0] {SEL_A, SEL_B, SEL_RSVD2, SEL_RSVD3} mem_sel_t;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

endpackage

// File: rtl/simple_dp_ram.sv
// One write port, one registered read port, read-first on address collision.
module simple_dp_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; the array contents are left as-is.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata_reg <= '0;
    else if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/tile_mem_responder.sv
// A/B/C matrix banks for the systolic controller, with host load/readback
// ports and a C-bank zero sweep that yields to controller writes.
module tile_mem_responder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   array_busy,
  input  logic                   mem_read_en_a,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_a,
  output logic [DATA_WIDTH-1:0]  mem_data_a,
  input  logic                   mem_read_en_b,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_b,
  output logic [DATA_WIDTH-1:0]  mem_data_b,
  input  logic                   mem_write_en_c,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_c,
  input  logic [ACCUM_WIDTH-1:0] mem_data_c,
  input  logic                   host_wr_valid,
  output logic                   host_wr_ready,
  input  logic [1:0]             host_wr_sel,
  input  logic [ADDR_WIDTH-1:0]  host_wr_addr,
  input  logic [DATA_WIDTH-1:0]  host_wr_data,
  input  logic                   host_rd_valid,
  output logic                   host_rd_ready,
  input  logic [ADDR_WIDTH-1:0]  host_rd_addr,
  output logic                   host_rd_rvalid,
  input  logic                   host_rd_rready,
  output logic [ACCUM_WIDTH-1:0] host_rd_rdata,
  input  logic                   clear_start,
  output logic                   clear_busy,
  output logic                   host_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  clr_state_t            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clr_addr_reg, clr_addr_next;
  logic                  sweep_we;
  logic                  rvalid_reg;
  logic                  err_reg;
  mem_sel_t              wr_sel;
  logic                  wr_fire, rd_fire;

  assign wr_sel        = mem_sel_t'(host_wr_sel);
  assign host_wr_ready = !array_busy && (state_reg == IDLE);
  assign host_rd_ready = host_wr_ready && (!rvalid_reg || host_rd_rready);
  // A beat presented while rst_n is low is never taken.
  assign wr_fire       = host_wr_valid && host_wr_ready && rst_n;
  assign rd_fire       = host_rd_valid && host_rd_ready && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  // A controller C write stalls the sweep for that cycle.
  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      IDLE: if (clear_start) state_next = CLEAR;
      CLEAR: begin
        if (!mem_write_en_c) begin
          clr_addr_next = clr_addr_reg + 1'b1;
          if (clr_addr_reg == LAST_ADDR) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (state_reg == CLEAR);
    sweep_we   = (state_reg == CLEAR) && !mem_write_en_c && rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      if (rd_fire)             rvalid_reg <= 1'b1;
      else if (host_rd_rready) rvalid_reg <= 1'b0;
      if (wr_fire && (wr_sel == SEL_RSVD2 || wr_sel == SEL_RSVD3)) err_reg <= 1'b1;
    end
  end

  assign host_rd_rvalid = rvalid_reg;
  assign host_err       = err_reg;

  simple_dp_ram #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_WIDTH)) u_ram_a (
    .clk(clk), .rst_n(rst_n),
    .we(wr_fire && wr_sel == SEL_A), .waddr(host_wr_addr), .wdata(host_wr_data),
    .re(mem_read_en_a), .raddr(mem_addr_a), .rdata(mem_data_a)
  );

  simple_dp_ram #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_WIDTH)) u_ram_b (
    .clk(clk), .rst_n(rst_n),
    .we(wr_fire && wr_sel == SEL_B), .waddr(host_wr_addr), .wdata(host_wr_data),
    .re(mem_read_en_b), .raddr(mem_addr_b), .rdata(mem_data_b)
  );

  simple_dp_ram #(.WIDTH(ACCUM_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_WIDTH)) u_ram_c (
    .clk(clk), .rst_n(rst_n),
    .we(mem_write_en_c || sweep_we),
    .waddr(mem_write_en_c ? mem_addr_c : clr_addr_reg),
    .wdata(mem_write_en_c ? mem_data_c : '0),
    .re(rd_fire), .raddr(host_rd_addr), .rdata(host_rd_rdata)
  );

endmodule

// File: tb/tb_tile_mem_responder.sv
// Randomised bench for tile_mem_responder against a behavioural bank model.
module tb_tile_mem_responder;
  localparam int DW = 8;
  localparam int CW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          array_busy;
  logic          mem_read_en_a, mem_read_en_b, mem_write_en_c;
  logic [AW-1:0] mem_addr_a, mem_addr_b, mem_addr_c;
  logic [DW-1:0] mem_data_a, mem_data_b;
  logic [CW-1:0] mem_data_c;
  logic          host_wr_valid, host_wr_ready;
  logic [1:0]    host_wr_sel;
  logic [AW-1:0] host_wr_addr;
  logic [DW-1:0] host_wr_data;
  logic          host_rd_valid, host_rd_ready, host_rd_rvalid, host_rd_rready;
  logic [AW-1:0] host_rd_addr;
  logic [CW-1:0] host_rd_rdata;
  logic          clear_start, clear_busy, host_err;

  always #5 clk = ~clk;

  tile_mem_responder #(.DATA_WIDTH(DW), .ACCUM_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .array_busy(array_busy),
    .mem_read_en_a(mem_read_en_a), .mem_addr_a(mem_addr_a), .mem_data_a(mem_data_a),
    .mem_read_en_b(mem_read_en_b), .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b),
    .mem_write_en_c(mem_write_en_c), .mem_addr_c(mem_addr_c), .mem_data_c(mem_data_c),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready), .host_wr_sel(host_wr_sel),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready), .host_rd_addr(host_rd_addr),
    .host_rd_rvalid(host_rd_rvalid), .host_rd_rready(host_rd_rready), .host_rd_rdata(host_rd_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .host_err(host_err)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  // Behavioural model: plain arrays plus the expected visible outputs.
  logic [DW-1:0] a_m [DEPTH];
  logic [DW-1:0] b_m [DEPTH];
  logic [CW-1:0] c_m [DEPTH];
  bit            m_clear = 0;
  int            m_clr = 0;
  logic [DW-1:0] e_a = '0, e_b = '0;
  logic [CW-1:0] e_rdata = '0;
  bit            e_rvalid = 0, e_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit wr_rdy, rd_rdy;
    if (!rst_n) begin
      m_clear = 0; m_clr = 0; e_a = '0; e_b = '0;
      e_rdata = '0; e_rvalid = 0; e_err = 0;
      return;
    end
    wr_rdy = !array_busy && !m_clear;
    rd_rdy = wr_rdy && (!e_rvalid || host_rd_rready);
    if (mem_read_en_a) e_a = a_m[mem_addr_a];
    if (mem_read_en_b) e_b = b_m[mem_addr_b];
    if (host_rd_valid && rd_rdy) begin
      e_rdata = c_m[host_rd_addr];
      e_rvalid = 1;
    end else if (host_rd_rready) begin
      e_rvalid = 0;
    end
    if (host_wr_valid && wr_rdy) begin
      case (host_wr_sel)
        2'd0:    a_m[host_wr_addr] = host_wr_data;
        2'd1:    b_m[host_wr_addr] = host_wr_data;
        default: e_err = 1;
      endcase
    end
    if (mem_write_en_c) c_m[mem_addr_c] = mem_data_c;
    if (m_clear) begin
      if (!mem_write_en_c) begin
        c_m[m_clr] = '0;
        if (m_clr == DEPTH - 1) m_clear = 0;
        m_clr = (m_clr + 1) % DEPTH;
      end
    end else if (clear_start) begin
      m_clear = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: registered outputs settle by 1 time unit after the edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (check_en) begin
      chk("mem_data_a", mem_data_a, e_a);
      chk("mem_data_b", mem_data_b, e_b);
      chk("rd_rvalid", host_rd_rvalid, e_rvalid);
      chk("rd_rdata", host_rd_rdata, e_rdata);
      chk("clear_busy", clear_busy, m_clear);
      chk("host_err", host_err, e_err);
      chk("wr_ready", host_wr_ready, !array_busy && !m_clear);
      chk("rd_ready", host_rd_ready, !array_busy && !m_clear && (!e_rvalid || host_rd_rready));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    array_busy = 0; mem_read_en_a = 0; mem_read_en_b = 0; mem_write_en_c = 0;
    mem_addr_a = '0; mem_addr_b = '0; mem_addr_c = '0; mem_data_c = '0;
    host_wr_valid = 0; host_wr_sel = 2'd0; host_wr_addr = '0; host_wr_data = '0;
    host_rd_valid = 0; host_rd_addr = '0; host_rd_rready = 0; clear_start = 0;
  endtask

  task automatic host_write(input int sel, input int addr, input int data);
    host_wr_valid = 1; host_wr_sel = sel[1:0]; host_wr_addr = addr[AW-1:0]; host_wr_data = data[DW-1:0];
    cyc();
    host_wr_valid = 0;
  endtask

  task automatic host_read(input int addr, output logic [CW-1:0] d);
    host_rd_valid = 1; host_rd_addr = addr[AW-1:0]; host_rd_rready = 0;
    cyc();
    host_rd_valid = 0;
    chk("host_read_rvalid", host_rd_rvalid, 1'b1);
    d = host_rd_rdata;
    host_rd_rready = 1;
    cyc();
    host_rd_rready = 0;
  endtask

  task automatic wait_clear_done();
    int n = 0;
    while (clear_busy && n < 5000) begin n++; cyc(); end
    chk("clear_done_bound", clear_busy, 1'b0);
  endtask

  logic [CW-1:0] rd;
  int n;

  initial begin
    idle_inputs();
    rst_n = 0;
    cyc(); cyc();
    check_en = 1;
    chk("rst_mem_data_a", mem_data_a, 8'h00);
    chk("rst_rvalid", host_rd_rvalid, 1'b0);
    chk("rst_clear_busy", clear_busy, 1'b0);
    chk("rst_host_err", host_err, 1'b0);
    chk("rst_wr_ready", host_wr_ready, 1'b1);
    rst_n = 1;

    for (int i = 0; i < DEPTH; i++) host_write(0, i, $urandom);
    for (int i = 0; i < DEPTH; i++) host_write(1, i, $urandom);

    host_write(0, 5, 8'h7F);
    mem_read_en_a = 1; mem_addr_a = 5; cyc(); mem_read_en_a = 0;
    chk("a5_read", mem_data_a, 8'h7F);
    mem_addr_a = 6; cyc();
    chk("a5_hold", mem_data_a, 8'h7F);

    array_busy = 1; host_wr_valid = 1; host_wr_sel = 2'd1; host_wr_addr = 3; host_wr_data = 8'h81;
    cyc();
    chk("busy_wr_ready", host_wr_ready, 1'b0);
    array_busy = 0; cyc(); host_wr_valid = 0;
    mem_read_en_b = 1; mem_addr_b = 3; cyc(); mem_read_en_b = 0;
    chk("b3_read", mem_data_b, 8'h81);

    host_write(3, 5, 8'h55);
    chk("rsvd_err", host_err, 1'b1);
    mem_read_en_a = 1; mem_addr_a = 5; cyc(); mem_read_en_a = 0;
    chk("rsvd_a5_kept", mem_data_a, 8'h7F);

    // Sweep with one controller write landing behind the sweep pointer.
    clear_start = 1; cyc(); clear_start = 0;
    n = 0;
    while (clear_busy && n < 5000) begin
      if (n == 10) begin
        mem_write_en_c = 1; mem_addr_c = 2; mem_data_c = 32'h1234_5678;
      end else begin
        mem_write_en_c = 0;
      end
      n++;
      cyc();
    end
    mem_write_en_c = 0;
    chk("clear_len", n, DEPTH + 1);

    host_rd_rready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      host_rd_valid = 1; host_rd_addr = i[AW-1:0]; cyc();
    end
    host_rd_valid = 0; cyc(); host_rd_rready = 0;
    host_read(2, rd);
    chk("c2_after_clear", rd, 32'h1234_5678);
    host_read(500, rd);
    chk("c500_zero", rd, 32'h0);

    mem_write_en_c = 1; mem_addr_c = 9; mem_data_c = 32'hFFFF_FFF0; cyc(); mem_write_en_c = 0;
    host_rd_valid = 1; host_rd_addr = 9; host_rd_rready = 0; cyc(); host_rd_valid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("hold_rvalid", host_rd_rvalid, 1'b1);
      chk("hold_rdata", host_rd_rdata, 32'hFFFF_FFF0);
      chk("hold_rd_ready", host_rd_ready, 1'b0);
      cyc();
    end
    host_rd_rready = 1; cyc(); host_rd_rready = 0;
    chk("hold_released", host_rd_rvalid, 1'b0);

    for (int t = 0; t < 3000; t++) begin
      array_busy     = ($urandom_range(0, 3) == 0);
      mem_read_en_a  = $urandom_range(0, 1);
      mem_addr_a     = AW'($urandom);
      mem_read_en_b  = $urandom_range(0, 1);
      mem_addr_b     = AW'($urandom);
      mem_write_en_c = ($urandom_range(0, 7) == 0);
      mem_addr_c     = AW'($urandom);
      mem_data_c     = $urandom;
      host_wr_valid  = $urandom_range(0, 1);
      host_wr_sel    = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 1));
      host_wr_addr   = AW'($urandom);
      host_wr_data   = DW'($urandom);
      host_rd_valid  = $urandom_range(0, 1);
      host_rd_addr   = AW'($urandom);
      host_rd_rready = $urandom_range(0, 1);
      clear_start    = ($urandom_range(0, 199) == 0);
      cyc();
    end
    idle_inputs();
    host_rd_rready = 1; cyc(); host_rd_rready = 0;
    wait_clear_done();

    // Reset mid-sweep with a response pending.
    host_write(0, 5, 8'h7F);
    mem_read_en_a = 1; mem_addr_a = 5; cyc(); mem_read_en_a = 0;
    host_rd_valid = 1; host_rd_addr = 9; cyc(); host_rd_valid = 0;
    clear_start = 1; cyc(); clear_start = 0;
    repeat (100) cyc();
    chk("pre_rst_busy", clear_busy, 1'b1);
    chk("pre_rst_rvalid", host_rd_rvalid, 1'b1);
    chk("pre_rst_err", host_err, 1'b1);
    rst_n = 0; cyc(); rst_n = 1;
    chk("post_rst_busy", clear_busy, 1'b0);
    chk("post_rst_rvalid", host_rd_rvalid, 1'b0);
    chk("post_rst_data_a", mem_data_a, 8'h00);
    chk("post_rst_err", host_err, 1'b0);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_mem_responder.md
# tile_mem_responder

Memory-side responder for the systolic array controller. It holds the A (activation), B (weight) and C (result) matrix banks, answers the controller's A/B read requests with fixed one-cycle latency, and accepts its C writes. It also gives the host a valid/ready port for loading A/B and reading back C, plus a C-bank clear sweep.

## Interface
Parameters:
- DATA_WIDTH, 8, A/B element width (signed)
- ACCUM_WIDTH, 32, C element width (signed)
- ADDR_WIDTH, 10, word address width; each bank has DEPTH = 2**ADDR_WIDTH words

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- array_busy  in  1  controller busy; blocks host access
- mem_read_en_a  in  1  controller A read request
- mem_addr_a  in  ADDR_WIDTH  A read address
- mem_data_a  out  DATA_WIDTH  A read data, registered
- mem_read_en_b  in  1  controller B read request
- mem_addr_b  in  ADDR_WIDTH  B read address
- mem_data_b  out  DATA_WIDTH  B read data, registered
- mem_write_en_c  in  1  controller C write strobe
- mem_addr_c  in  ADDR_WIDTH  C write address
- mem_data_c  in  ACCUM_WIDTH  C write data
- host_wr_valid / host_wr_ready  in / out  1  host write handshake
- host_wr_sel  in  2  target bank: 0 = A, 1 = B, 2 and 3 reserved
- host_wr_addr  in  ADDR_WIDTH  host write address
- host_wr_data  in  DATA_WIDTH  host write data
- host_rd_valid / host_rd_ready  in / out  1  host C-read request handshake
- host_rd_addr  in  ADDR_WIDTH  host C-read address
- host_rd_rvalid / host_rd_rready  out / in  1  host read-response handshake
- host_rd_rdata  out  ACCUM_WIDTH  C read data
- clear_start  in  1  pulse; starts the C-bank zero sweep
- clear_busy  out  1  sweep in progress
- host_err  out  1  sticky error flag; cleared only by reset

## Operation
- State machine states: IDLE and CLEAR.
  - IDLE goes to CLEAR on clear_start; clear_start is ignored while in CLEAR.
  - CLEAR writes 0 to C[clr_addr], then increments clr_addr.
  - CLEAR goes back to IDLE after the write to DEPTH-1; clr_addr wraps to 0.
- Controller A/B reads: when mem_read_en_x is high at edge N, mem_data_x equals X[mem_addr_x] after edge N. When read_en is low, mem_data_x holds its last value.
- Controller C writes:
  - Committed at the edge where mem_write_en_c is high, in either state.
  - In CLEAR, a controller write takes the C write port. The sweep stalls that cycle: clr_addr is held and nothing is zeroed that cycle.
- host_wr_ready = !array_busy && state==IDLE.
  - On an accepted beat with sel 0 or 1, the data is written to bank A or B.
  - On an accepted beat with sel 2 or 3, the beat is accepted, the data is dropped, and host_err is set.
- host_rd_ready = !array_busy && state==IDLE && (!host_rd_rvalid || host_rd_rready).
  - On an accepted request, host_rd_rvalid and host_rd_rdata (= C[host_rd_addr]) become valid the next cycle.
  - Response data is held stable until host_rd_rready is high.
  - At most one response is outstanding.
- Same-address read and write in one cycle return the old data (read-first) on every bank.
- Data is passed through unmodified: no sign extension, truncation or arithmetic.

## Timing
- Reset values: mem_data_a=0, mem_data_b=0, host_rd_rdata=0, host_rd_rvalid=0, clear_busy=0, host_err=0, state=IDLE, clr_addr=0. host_wr_ready and host_rd_ready follow their equations above.
- RAM contents are not reset.
- Read latency is 1 cycle for the controller A/B ports and for the host C-read response.
- Host writes are committed at the accepting edge.
- clear_busy rises the cycle after clear_start is sampled.
- An unstalled sweep takes DEPTH cycles; clear_busy falls after the DEPTH-1 write.
- Each controller C write during CLEAR adds one cycle to the sweep.
- array_busy rising while a host response is pending does not cancel the response; it still completes on rready.
- rst_n low in the middle of a sweep or with a response pending: next cycle is IDLE with rvalid=0. C is left partially cleared.
- rst_n low while a host beat is presented: the beat is not accepted.

## Structure
- Shared package systolic_pkg holds:
  - mem_sel_t enum: SEL_A, SEL_B, SEL_RSVD2, SEL_RSVD3
  - clr_state_t enum: IDLE, CLEAR
  - the DATA_WIDTH, ACCUM_WIDTH and ADDR_WIDTH defaults
- One sub-module, simple_dp_ram, parameterised by width and depth. It has one write port, one registered read port and read-first behaviour.
  - Instantiated three times.
  - The A and B instances: write port from the host, read port from the controller.
  - The C instance: write port muxed between controller write and sweep (controller wins); read port from the host.

## Test plan
- Host writes A[5]=0x7F, then the controller reads address 5 -> mem_data_a = 0x7F one cycle after read_en; with read_en low it holds 0x7F.
- array_busy=1 with host_wr_valid=1 -> host_wr_ready=0 and no write. Drop busy -> accepted next edge and B[3]=0x81 reads back as 0x81.
- Controller writes C[9]=32'hFFFF_FFF0; host reads 9 holding rready=0 for 3 cycles -> rvalid stays high with rdata=0xFFFF_FFF0 throughout, and host_rd_ready=0.
- clear_start with one controller C write at cycle 10 -> clear_busy high for DEPTH+1 cycles; every C address except the written one reads 0; the written address holds its write if it came after that address was swept.
- host_wr_sel=3 beat -> accepted, host_err=1, A and B unchanged, host_err remains 1 until rst_n.
- rst_n low for one cycle at sweep cycle 100 -> next cycle clear_busy=0, rvalid=0, mem_data_a=0, host_err=0.
